// File: rtl/led_ctrl_pkg.sv
// Shared mode encodings and breathe-state type for the LED driver.
package led_ctrl_pkg;

  localparam logic [2:0] LED_OFF     = 3'd0;
  localparam logic [2:0] LED_ON      = 3'd1;
  localparam logic [2:0] LED_BLINK   = 3'd2;
  localparam logic [2:0] LED_PWM     = 3'd3;
  localparam logic [2:0] LED_BREATHE = 3'd4;

  typedef enum logic {
    BR_UP   = 1'b0,
    BR_DOWN = 1'b1
  } br_state_e;

endpackage

// File: rtl/led_chan.sv
// One LED channel: blink phase, breathe envelope and the registered pad driver.
module led_chan
  import led_ctrl_pkg::*;
#(
  parameter int PWM_BITS   = 8,
  parameter int BLINK_BITS = 10
) (
  input  logic                  clk,
  input  logic                  reset_,
  input  logic                  tick,
  input  logic [PWM_BITS-1:0]   pwm_cntr,
  input  logic [2:0]            mode,
  input  logic [PWM_BITS-1:0]   duty,
  input  logic [BLINK_BITS-1:0] blink_half,
  output logic                  led
);

  localparam logic [PWM_BITS-1:0]   P_ONE = 1;
  localparam logic [BLINK_BITS-1:0] B_ONE = 1;

  logic [2:0]            mode_q;
  logic                  phase_q, phase_d;
  logic [BLINK_BITS-1:0] half_q, half_d;
  logic [PWM_BITS-1:0]   bright_q, bright_d;
  br_state_e             st_q, st_d;
  logic                  led_q, d;

  logic                  mode_chg;
  logic [BLINK_BITS-1:0] half_max;
  logic [PWM_BITS-1:0]   bright_eff;

  assign mode_chg   = (mode != mode_q);
  // blink_half of 0 behaves like 1: toggle on every tick
  assign half_max   = (blink_half == '0) ? '0 : blink_half - B_ONE;
  assign bright_eff = mode_chg ? '0 : bright_q;

  always_comb begin
    phase_d  = phase_q;
    half_d   = half_q;
    bright_d = bright_q;
    st_d     = st_q;
    if (mode_chg) begin
      phase_d  = 1'b0;
      half_d   = '0;
      bright_d = '0;
      st_d     = BR_UP;
    end else begin
      if (mode == LED_BLINK && tick) begin
        if (half_q >= half_max) begin
          phase_d = ~phase_q;
          half_d  = '0;
        end else begin
          half_d  = half_q + B_ONE;
        end
      end
      if (mode == LED_BREATHE) begin
        if (bright_q > duty) begin
          bright_d = duty;
          st_d     = BR_DOWN;
        end else if (tick) begin
          if (st_q == BR_UP) begin
            if (bright_q < duty) begin
              bright_d = bright_q + P_ONE;
              if (bright_q + P_ONE == duty) st_d = BR_DOWN;
            end else begin
              st_d = BR_DOWN;
            end
          end else begin
            if (bright_q != '0) begin
              bright_d = bright_q - P_ONE;
              if (bright_q == P_ONE) st_d = BR_UP;
            end else begin
              st_d = BR_UP;
            end
          end
        end
      end
    end
  end

  always_comb begin
    d = 1'b0;
    case (mode)
      LED_ON:      d = 1'b1;
      LED_BLINK:   d = mode_chg ? 1'b0 : phase_q;
      LED_PWM:     d = (pwm_cntr < duty);
      LED_BREATHE: d = (pwm_cntr < bright_eff);
      default:     d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      mode_q   <= LED_OFF;
      phase_q  <= 1'b0;
      half_q   <= '0;
      bright_q <= '0;
      st_q     <= BR_UP;
      led_q    <= 1'b0;
    end else begin
      mode_q   <= mode;
      phase_q  <= phase_d;
      half_q   <= half_d;
      bright_q <= bright_d;
      st_q     <= st_d;
      led_q    <= d;
    end
  end

  assign led = led_q;

endmodule

// File: rtl/led_ctrl.sv
// Multi-channel LED driver: shared prescaler tick and PWM counter feeding per-channel drivers.
module led_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int NR_CHANNELS = 3,
  parameter int PRESCALE    = 25000,
  parameter int PWM_BITS    = 8,
  parameter int BLINK_BITS  = 10
) (
  input  logic                            clk,
  input  logic                            reset_,
  input  logic [3*NR_CHANNELS-1:0]        ch_mode,
  input  logic [PWM_BITS*NR_CHANNELS-1:0] ch_duty,
  input  logic [BLINK_BITS-1:0]           blink_half,
  output logic [NR_CHANNELS-1:0]          led_out,
  output logic                            tick
);

  localparam int                PS_W    = $clog2(PRESCALE);
  localparam logic [PS_W-1:0]   PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [PS_W-1:0]   PS_ONE  = 1;
  localparam logic [PWM_BITS-1:0] P_ONE = 1;

  logic [PS_W-1:0]     presc_q, presc_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic                tick_q, tick_d;

  assign presc_d = (presc_q == PS_LAST) ? '0 : presc_q + PS_ONE;
  assign pwm_d   = pwm_q + P_ONE;
  // tick lands the cycle after the prescaler sits at its last count
  assign tick_d  = (presc_q == PS_LAST);

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      presc_q <= '0;
      pwm_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      pwm_q   <= pwm_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

  for (genvar i = 0; i < NR_CHANNELS; i++) begin : g_ch
    led_chan #(
      .PWM_BITS   (PWM_BITS),
      .BLINK_BITS (BLINK_BITS)
    ) u_chan (
      .clk        (clk),
      .reset_     (reset_),
      .tick       (tick_q),
      .pwm_cntr   (pwm_q),
      .mode       (ch_mode[3*i +: 3]),
      .duty       (ch_duty[PWM_BITS*i +: PWM_BITS]),
      .blink_half (blink_half),
      .led        (led_out[i])
    );
  end

endmodule

// File: tb/tb_led_ctrl.sv
// Directed bench for led_ctrl with PRESCALE=4, PWM_BITS=4, BLINK_BITS=4, 3 channels.
module tb_led_ctrl;
  import led_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset_;
  logic [8:0]  ch_mode;
  logic [11:0] ch_duty;
  logic [3:0]  blink_half;
  logic [2:0]  led_out;
  logic        tick;

  int tests = 0;
  int fails = 0;
  int ec    = 0;
  int seq [6] = '{1, 2, 3, 2, 1, 0};

  led_ctrl #(
    .NR_CHANNELS (3),
    .PRESCALE    (4),
    .PWM_BITS    (4),
    .BLINK_BITS  (4)
  ) dut (
    .clk        (clk),
    .reset_     (reset_),
    .ch_mode    (ch_mode),
    .ch_duty    (ch_duty),
    .blink_half (blink_half),
    .led_out    (led_out),
    .tick       (tick)
  );

  always #5 clk = ~clk;

  // rising edges since the last reset release
  always @(posedge clk or negedge reset_)
    if (!reset_) ec <= 0;
    else         ec <= ec + 1;

  task automatic wait_led(input int ch, input logic val, input int budget, output int at);
    int n;
    at = -1;
    n  = 0;
    while (at < 0 && n < budget) begin
      @(negedge clk);
      if (led_out[ch] === val) at = ec;
      n++;
    end
  endtask

  task automatic align4();
    do @(negedge clk); while (ec % 4 != 0);
  endtask

  task automatic test_reset();
    logic et;
    reset_ = 1'b0; ch_mode = '0; ch_duty = '0; blink_half = '0;
    repeat (3) @(negedge clk);
    tests++;
    if (led_out !== 3'b000 || tick !== 1'b0) begin
      fails++; $display("FAIL reset_state: led_out=%b tick=%b want 000/0", led_out, tick);
    end
    reset_ = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      et = (k % 4 == 0);
      tests++;
      if (tick !== et || led_out !== 3'b000) begin
        fails++; $display("FAIL tick_cycle%0d: tick=%b led=%b want %b/000", k, tick, led_out, et);
      end
    end
  endtask

  task automatic test_pwm_static();
    logic [2:0] exp;
    ch_mode = {LED_PWM, LED_OFF, LED_ON};
    ch_duty = {4'd4, 4'd0, 4'd0};
    @(negedge clk);
    for (int n = 0; n < 32; n++) begin
      @(negedge clk);
      exp = {((ec - 1) % 16) < 4, 1'b0, 1'b1};
      tests++;
      if (led_out !== exp) begin
        fails++; $display("FAIL pwm_static@%0d: led=%b want %b", ec, led_out, exp);
      end
    end
  endtask

  task automatic test_pwm_bounds();
    logic [2:0] exp;
    ch_mode = {3'd5, LED_PWM, LED_PWM};
    ch_duty = {4'd0, 4'd15, 4'd0};
    @(negedge clk);
    for (int n = 0; n < 32; n++) begin
      @(negedge clk);
      exp = {1'b0, ((ec - 1) % 16) < 15, 1'b0};
      tests++;
      if (led_out !== exp) begin
        fails++; $display("FAIL pwm_bounds@%0d: led=%b want %b", ec, led_out, exp);
      end
    end
  endtask

  task automatic test_blink();
    int m, at;
    blink_half = 4'd3;
    ch_mode    = {LED_OFF, LED_OFF, LED_OFF};
    align4();
    ch_mode = {LED_OFF, LED_OFF, LED_BLINK};
    m = ec + 1;
    wait_led(0, 1'b1, 40, at);
    tests++;
    if (at != m + 13) begin fails++; $display("FAIL blink3_rise: at=%0d want %0d", at, m + 13); end
    wait_led(0, 1'b0, 20, at);
    tests++;
    if (at != m + 25) begin fails++; $display("FAIL blink3_fall: at=%0d want %0d", at, m + 25); end
    blink_half = 4'd0;
    wait_led(0, 1'b1, 10, at);
    tests++;
    if (at != m + 29) begin fails++; $display("FAIL blink0_rise: at=%0d want %0d", at, m + 29); end
    wait_led(0, 1'b0, 10, at);
    tests++;
    if (at != m + 33) begin fails++; $display("FAIL blink0_fall: at=%0d want %0d", at, m + 33); end
  endtask

  task automatic test_breathe();
    int m, e, b;
    logic [2:0] exp;
    ch_duty = {4'd0, 4'd3, 4'd0};
    align4();
    ch_mode = {LED_OFF, LED_BREATHE, LED_OFF};
    m = ec + 1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      e = ec - 1;
      b = (e < m + 4) ? 0 : seq[((e - m) / 4 - 1) % 6];
      exp = {1'b0, ((ec - 1) % 16) < b, 1'b0};
      tests++;
      if (led_out !== exp) begin
        fails++; $display("FAIL breathe@%0d: led=%b want %b (bright %0d)", ec, led_out, exp, b);
      end
    end
  endtask

  task automatic test_switch();
    int m, at;
    blink_half = 4'd2;
    ch_duty    = {4'd15, 4'd0, 4'd0};
    ch_mode    = {LED_PWM, LED_OFF, LED_OFF};
    @(negedge clk);
    do @(negedge clk); while (ec % 16 != 7);
    tests++;
    if (led_out[2] !== 1'b1) begin fails++; $display("FAIL switch_pre: led2=%b want 1", led_out[2]); end
    ch_mode = {LED_BLINK, LED_OFF, LED_OFF};
    m = ec + 1;
    @(negedge clk);
    tests++;
    if (led_out[2] !== 1'b0) begin fails++; $display("FAIL switch_clear: led2=%b want 0", led_out[2]); end
    wait_led(2, 1'b1, 20, at);
    tests++;
    if (at != m + 6) begin fails++; $display("FAIL switch_toggle: at=%0d want %0d", at, m + 6); end
  endtask

  task automatic test_reset_mid();
    int m, e, b;
    logic [2:0] exp;
    ch_duty = {4'd0, 4'd3, 4'd0};
    align4();
    ch_mode = {LED_OFF, LED_BREATHE, LED_ON};
    m = ec + 1;
    while (ec < m + 9) @(negedge clk);
    tests++;
    if (led_out[0] !== 1'b1) begin fails++; $display("FAIL rstmid_pre: led0=%b want 1", led_out[0]); end
    #2 reset_ = 1'b0;
    #1;
    tests++;
    if (led_out !== 3'b000 || tick !== 1'b0) begin
      fails++; $display("FAIL rstmid_async: led=%b tick=%b want 000/0", led_out, tick);
    end
    @(negedge clk);
    reset_ = 1'b1;
    for (int n = 0; n < 24; n++) begin
      @(negedge clk);
      e = ec - 1;
      b = (e < 5) ? 0 : seq[((e - 1) / 4 - 1) % 6];
      exp = {1'b0, ((ec - 1) % 16) < b, 1'b1};
      tests++;
      if (led_out !== exp) begin
        fails++; $display("FAIL rstmid_restart@%0d: led=%b want %b", ec, led_out, exp);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: tests=%0d failed=%0d", tests, fails);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_pwm_static();
    test_pwm_bounds();
    test_blink();
    test_breathe();
    test_switch();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
